// File: rtl/la_sequencer.sv
// Logic-analyser command sequencer: decodes host bytes, arms the trigger, then grants the RAM to capture and later to transmit.
// Latency: a command byte changes state on the next edge; a registered trigger compare adds one more cycle; grants track the state register.
// Backpressure: none -- rx_data_valid is a strobe that cannot be stalled; bytes not meaningful in the current state are dropped.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_data, rx_data_valid        command/operand byte and its one-cycle strobe
//   sample_in                     synchronised probe inputs compared against the trigger
//   cap_grant, cap_done           capture engine enable / buffer-full pulse
//   cap_wr_en, cap_wr_addr        capture-side RAM write request
//   tx_grant, tx_done, tx_rd_addr transmit engine enable / finished pulse / read address
//   ram_addr, ram_we              shared sample RAM port (combinational mux)
//   busy, run_count               not-idle flag, completed capture+transmit runs (wraps)
module la_sequencer #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_data_valid,
  input  logic [7:0]        sample_in,
  output logic              cap_grant,
  input  logic              cap_done,
  input  logic              cap_wr_en,
  input  logic [ADDR_W-1:0] cap_wr_addr,
  output logic              tx_grant,
  input  logic              tx_done,
  input  logic [ADDR_W-1:0] tx_rd_addr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              busy,
  output logic [7:0]        run_count
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_MASK  = 3'd1,
    S_GET_VALUE = 3'd2,
    S_ARMED     = 3'd3,
    S_CAPTURE   = 3'd4,
    S_TRANSMIT  = 3'd5
  } state_t;

  localparam logic [7:0] CMD_ARM   = 8'h01;
  localparam logic [7:0] CMD_MASK  = 8'h02;
  localparam logic [7:0] CMD_VALUE = 8'h03;
  localparam logic [7:0] CMD_ABORT = 8'h04;
  localparam logic [7:0] CMD_FORCE = 8'h05;

  state_t     r_state;
  logic [7:0] r_trig_mask;
  logic [7:0] r_trig_value;
  logic       r_trig;
  logic       r_cap_grant;
  logic       r_tx_grant;
  logic [7:0] r_run_count;

  logic w_match;
  logic w_abort;
  logic w_force;

  // Masked-off bits never block a match, so an all-zero mask matches any sample.
  assign w_match = (((sample_in ^ r_trig_value) & r_trig_mask) == 8'h00);
  assign w_abort = rx_data_valid && (rx_data == CMD_ABORT);
  assign w_force = rx_data_valid && (rx_data == CMD_FORCE);

  // Grants are updated alongside the state so each one is high exactly while
  // its state is resident; leaving a state drops its grant on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_trig_mask  <= 8'h00;
      r_trig_value <= 8'h00;
      r_trig       <= 1'b0;
      r_cap_grant  <= 1'b0;
      r_tx_grant   <= 1'b0;
      r_run_count  <= 8'h00;
    end else begin
      // The compare result is only meaningful while armed; clearing it elsewhere
      // guarantees a fresh arm never acts on a stale match.
      r_trig <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (rx_data_valid) begin
            case (rx_data)
              CMD_ARM:   r_state <= S_ARMED;
              CMD_MASK:  r_state <= S_GET_MASK;
              CMD_VALUE: r_state <= S_GET_VALUE;
              default:   r_state <= S_IDLE;
            endcase
          end
        end

        S_GET_MASK: begin
          if (rx_data_valid) begin
            r_trig_mask <= rx_data;
            r_state     <= S_IDLE;
          end
        end

        S_GET_VALUE: begin
          if (rx_data_valid) begin
            r_trig_value <= rx_data;
            r_state      <= S_IDLE;
          end
        end

        S_ARMED: begin
          r_trig <= w_match;
          // Abort outranks both the registered trigger and a force.
          if (w_abort) begin
            r_state <= S_IDLE;
          end else if (r_trig || w_force) begin
            r_state     <= S_CAPTURE;
            r_cap_grant <= 1'b1;
          end
        end

        S_CAPTURE: begin
          // A full buffer wins over a late abort so captured data is still dumped.
          if (cap_done) begin
            r_state     <= S_TRANSMIT;
            r_cap_grant <= 1'b0;
            r_tx_grant  <= 1'b1;
          end else if (w_abort) begin
            r_state     <= S_IDLE;
            r_cap_grant <= 1'b0;
          end
        end

        S_TRANSMIT: begin
          // Commands are deliberately not decoded here: a dump always runs to completion.
          if (tx_done) begin
            r_state     <= S_IDLE;
            r_tx_grant  <= 1'b0;
            r_run_count <= r_run_count + 8'd1;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_cap_grant <= 1'b0;
          r_tx_grant  <= 1'b0;
        end
      endcase
    end
  end

  assign cap_grant = r_cap_grant;
  assign tx_grant  = r_tx_grant;
  assign busy      = (r_state != S_IDLE);
  assign run_count = r_run_count;

  // The capture engine owns the RAM only while granted; otherwise the port is
  // a read for the transmit engine and writes are suppressed.
  assign ram_addr = r_cap_grant ? cap_wr_addr : tx_rd_addr;
  assign ram_we   = r_cap_grant & cap_wr_en;

endmodule

// File: tb/tb_la_sequencer.sv
// Testbench for la_sequencer: hand-tabled command sequences, run-counter wrap, then randomized traffic against a reference model.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: not applicable; the bench drives strobes freely.
module tb_la_sequencer;

  localparam int ADDR_W = 10;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_data_valid;
  logic [7:0]        sample_in;
  logic              cap_grant;
  logic              cap_done;
  logic              cap_wr_en;
  logic [ADDR_W-1:0] cap_wr_addr;
  logic              tx_grant;
  logic              tx_done;
  logic [ADDR_W-1:0] tx_rd_addr;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              busy;
  logic [7:0]        run_count;

  la_sequencer #(.ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .sample_in     (sample_in),
    .cap_grant     (cap_grant),
    .cap_done      (cap_done),
    .cap_wr_en     (cap_wr_en),
    .cap_wr_addr   (cap_wr_addr),
    .tx_grant      (tx_grant),
    .tx_done       (tx_done),
    .tx_rd_addr    (tx_rd_addr),
    .ram_addr      (ram_addr),
    .ram_we        (ram_we),
    .busy          (busy),
    .run_count     (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phases named after the host-visible behaviour. The trigger is described as
  // "while armed, the previous cycle's sample matched", kept as a one-cycle history.
  localparam int P_IDLE = 0, P_MASK = 1, P_VALUE = 2, P_ARMED = 3, P_CAP = 4, P_TX = 5;
  int         m_phase = P_IDLE;
  logic [7:0] m_mask  = 8'h00;
  logic [7:0] m_value = 8'h00;
  logic [7:0] m_runs  = 8'h00;
  bit         m_prev_hit = 1'b0;

  task automatic model_edge();
    bit hit_now;
    int cmd;
    if (rst) begin
      m_phase = P_IDLE; m_mask = 8'h00; m_value = 8'h00; m_runs = 8'h00; m_prev_hit = 1'b0;
      return;
    end
    hit_now = (m_phase == P_ARMED) && (((sample_in ^ m_value) & m_mask) == 8'h00);
    cmd = rx_data_valid ? int'(rx_data) : -1;
    case (m_phase)
      P_IDLE:  if (cmd == 1) m_phase = P_ARMED; else if (cmd == 2) m_phase = P_MASK;
               else if (cmd == 3) m_phase = P_VALUE;
      P_MASK:  if (cmd >= 0) begin m_mask = rx_data; m_phase = P_IDLE; end
      P_VALUE: if (cmd >= 0) begin m_value = rx_data; m_phase = P_IDLE; end
      P_ARMED: if (cmd == 4) m_phase = P_IDLE; else if (m_prev_hit || cmd == 5) m_phase = P_CAP;
      P_CAP:   if (cap_done) m_phase = P_TX; else if (cmd == 4) m_phase = P_IDLE;
      P_TX:    if (tx_done) begin m_phase = P_IDLE; m_runs = m_runs + 8'd1; end
      default: m_phase = P_IDLE;
    endcase
    m_prev_hit = hit_now;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant_exclusive", 32'(cap_grant && tx_grant), 32'd0);
    chk("we_implies_capgrant", 32'(ram_we && !cap_grant), 32'd0);
  endtask

  task automatic cmp_model(input string tag);
    bit cg;
    cg = (m_phase == P_CAP);
    chk({tag, ".cap_grant"}, 32'(cap_grant), 32'(cg));
    chk({tag, ".tx_grant"},  32'(tx_grant),  32'(m_phase == P_TX));
    chk({tag, ".busy"},      32'(busy),      32'(m_phase != P_IDLE));
    chk({tag, ".run_count"}, 32'(run_count), 32'(m_runs));
    chk({tag, ".ram_we"},    32'(ram_we),    32'(cg && cap_wr_en));
    chk({tag, ".ram_addr"},  32'(ram_addr),  32'(cg ? cap_wr_addr : tx_rd_addr));
  endtask

  task automatic drive(input bit r, input bit vl, input logic [7:0] d, input logic [7:0] s,
                       input bit cd, input bit td, input bit we,
                       input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] ra);
    rst = r; rx_data_valid = vl; rx_data = d; sample_in = s;
    cap_done = cd; tx_done = td; cap_wr_en = we; cap_wr_addr = wa; tx_rd_addr = ra;
  endtask

  // ---------------- hand-written vector table ----------------
  typedef struct {
    bit         r;
    bit         vl;
    logic [7:0] d;
    logic [7:0] s;
    bit         cd;
    bit         td;
    bit         e_cg;
    bit         e_tg;
    bit         e_busy;
    logic [7:0] e_rc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit vl, logic [7:0] d, logic [7:0] s, bit cd, bit td,
                              bit cg, bit tg, bit b, logic [7:0] rc);
    vec_t v;
    v.r = r; v.vl = vl; v.d = d; v.s = s; v.cd = cd; v.td = td;
    v.e_cg = cg; v.e_tg = tg; v.e_busy = b; v.e_rc = rc;
    return v;
  endfunction

  localparam logic [ADDR_W-1:0] WA = 10'h155;
  localparam logic [ADDR_W-1:0] RA = 10'h0AA;

  initial begin
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, '0, '0);

    //              r  vl  d      s      cd td   cg tg busy rc
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // reset
    tbl.push_back(mk(0, 1, 8'h02, 8'h00, 0, 0,   0, 0, 1, 8'd0)); // -> GET_MASK
    tbl.push_back(mk(0, 1, 8'hF0, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // mask=F0
    tbl.push_back(mk(0, 1, 8'h03, 8'h00, 0, 0,   0, 0, 1, 8'd0)); // -> GET_VALUE
    tbl.push_back(mk(0, 1, 8'hA0, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // value=A0
    tbl.push_back(mk(0, 1, 8'h01, 8'h00, 0, 0,   0, 0, 1, 8'd0)); // -> ARMED
    tbl.push_back(mk(0, 0, 8'h00, 8'h5F, 0, 0,   0, 0, 1, 8'd0)); // 0x5F: no match
    tbl.push_back(mk(0, 0, 8'h00, 8'hA3, 0, 0,   0, 0, 1, 8'd0)); // 0x5F did not trigger
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0,   1, 0, 1, 8'd0)); // 2nd edge after 0xA3: CAPTURE
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0,   1, 0, 1, 8'd0)); // hold, RAM writes pass
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0,   0, 1, 1, 8'd0)); // cap_done -> TRANSMIT
    tbl.push_back(mk(0, 1, 8'h04, 8'h00, 0, 0,   0, 1, 1, 8'd0)); // abort ignored in TRANSMIT
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0,   0, 1, 1, 8'd0)); // stray cap_done ignored
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1,   0, 0, 0, 8'd1)); // tx_done -> IDLE, run 1
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 1,   0, 0, 0, 8'd1)); // stray tx_done ignored
    tbl.push_back(mk(0, 1, 8'h05, 8'h00, 0, 0,   0, 0, 0, 8'd1)); // force ignored in IDLE
    tbl.push_back(mk(0, 1, 8'h01, 8'h00, 0, 0,   0, 0, 1, 8'd1)); // -> ARMED (00 mismatches)
    tbl.push_back(mk(0, 1, 8'h05, 8'h00, 0, 0,   1, 0, 1, 8'd1)); // force -> CAPTURE
    tbl.push_back(mk(0, 1, 8'h04, 8'h00, 0, 0,   0, 0, 0, 8'd1)); // abort -> IDLE, grant drops
    tbl.push_back(mk(0, 1, 8'h01, 8'h00, 0, 0,   0, 0, 1, 8'd1)); // -> ARMED
    tbl.push_back(mk(0, 1, 8'h05, 8'h00, 0, 0,   1, 0, 1, 8'd1)); // force -> CAPTURE
    tbl.push_back(mk(0, 1, 8'h04, 8'h00, 1, 0,   0, 1, 1, 8'd1)); // cap_done beats abort
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // reset mid-TRANSMIT
    tbl.push_back(mk(0, 1, 8'h01, 8'h37, 0, 0,   0, 0, 1, 8'd0)); // -> ARMED, mask back to 0
    tbl.push_back(mk(0, 0, 8'h00, 8'h37, 0, 0,   0, 0, 1, 8'd0)); // first compare cycle
    tbl.push_back(mk(0, 0, 8'h00, 8'h37, 0, 0,   1, 0, 1, 8'd0)); // zero mask triggers
    tbl.push_back(mk(1, 0, 8'h00, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // reset mid-CAPTURE
    tbl.push_back(mk(0, 1, 8'h02, 8'h00, 0, 0,   0, 0, 1, 8'd0)); // -> GET_MASK
    tbl.push_back(mk(0, 1, 8'hFF, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // mask=FF, value=00
    tbl.push_back(mk(0, 1, 8'h01, 8'h55, 0, 0,   0, 0, 1, 8'd0)); // -> ARMED
    tbl.push_back(mk(0, 1, 8'h00, 8'h55, 0, 0,   0, 0, 1, 8'd0)); // unlisted byte, no match
    tbl.push_back(mk(0, 1, 8'h04, 8'h55, 0, 0,   0, 0, 0, 8'd0)); // abort -> IDLE, no grant
    tbl.push_back(mk(0, 1, 8'h01, 8'h00, 0, 0,   0, 0, 1, 8'd0)); // -> ARMED
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 0, 0,   0, 0, 1, 8'd0)); // match registered
    tbl.push_back(mk(0, 1, 8'h04, 8'h00, 0, 0,   0, 0, 0, 8'd0)); // abort beats trigger
    tbl.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0,   0, 0, 0, 8'd0)); // cap_done in IDLE ignored

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].vl, tbl[i].d, tbl[i].s, tbl[i].cd, tbl[i].td, 1'b1, WA, RA);
      tick();
      chk($sformatf("row%0d.cap_grant", i), 32'(cap_grant), 32'(tbl[i].e_cg));
      chk($sformatf("row%0d.tx_grant", i),  32'(tx_grant),  32'(tbl[i].e_tg));
      chk($sformatf("row%0d.busy", i),      32'(busy),      32'(tbl[i].e_busy));
      chk($sformatf("row%0d.run_count", i), 32'(run_count), 32'(tbl[i].e_rc));
      chk($sformatf("row%0d.ram_we", i),    32'(ram_we),    32'(tbl[i].e_cg));
      chk($sformatf("row%0d.ram_addr", i),  32'(ram_addr),  tbl[i].e_cg ? 32'(WA) : 32'(RA));
    end

    // 256 complete runs: arm, force, fill, stray abort during dump, finish.
    for (int k = 0; k < 256; k++) begin
      drive(0, 1, 8'h01, 8'h55, 0, 0, 1, 10'(k), 10'(1023 - k)); tick(); cmp_model("wrap_arm");
      drive(0, 1, 8'h05, 8'h55, 0, 0, 1, 10'(k), 10'(1023 - k)); tick(); cmp_model("wrap_force");
      drive(0, 0, 8'h00, 8'h55, 1, 0, 1, 10'(k), 10'(1023 - k)); tick(); cmp_model("wrap_capdone");
      drive(0, 1, 8'h04, 8'h55, 0, 0, 1, 10'(k), 10'(1023 - k)); tick(); cmp_model("wrap_txabort");
      drive(0, 0, 8'h00, 8'h55, 0, 1, 1, 10'(k), 10'(1023 - k)); tick(); cmp_model("wrap_txdone");
      chk("wrap_run_count", 32'(run_count), 32'((k + 1) % 256));
    end

    // Randomized traffic: commands biased to the meaningful ones, samples biased
    // towards the programmed value so triggers actually fire.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      logic [7:0] s;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      s = ($urandom_range(0, 2) == 0) ? (m_value ^ (8'($urandom_range(0, 255)) & ~m_mask))
                                     : 8'($urandom_range(0, 255));
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, d, s,
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
            10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)));
      tick();
      cmp_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
